// File: rtl/afficheur7s_mux.sv
// Multiplexed 7-segment hex display driver.
// Scans NDIGITS digits, one prescaler period (DIV cycles) per slot. Each slot
// opens with GAP blanked cycles to suppress ghosting. S/AN are registered.
// Optional leading-zero blanking is enabled by defining AFFICHEUR7S_LZB_EN.
// Segment bit order: s[0]=a .. s[6]=g.
module afficheur7s_mux #(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned GAP          = 16,
  parameter int unsigned COMMON_ANODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   e,
  input  logic                   load,
  input  logic [NDIGITS-1:0]     blank,
  output logic [6:0]             s,
  output logic [NDIGITS-1:0]     an,
  output logic [2:0]             digit_idx
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
  localparam logic [CW-1:0] CntGap = CW'(GAP);
  localparam logic [6:0] SegOff = (COMMON_ANODE != 0) ? 7'h7f : 7'h00;
  localparam logic [NDIGITS-1:0] AnOff = (COMMON_ANODE != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

  typedef enum logic {StGap, StDrive} state_e;

  logic [1:0]           sync_q;
  logic                 run;
  logic [4*NDIGITS-1:0] e_q;
  logic [NDIGITS-1:0]   blank_q, blank_eff;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 wrap;
  state_e               state_q, state_d;
  logic [3:0]           nib;
  logic                 blk;
  logic [6:0]           seg, s_d, s_q;
  logic [NDIGITS-1:0]   an_d, an_q;

  // Hex font, returned as {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] v);
    unique case (v)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0100111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
      4'ha: font = 7'b1110111;
      4'hb: font = 7'b1111100;
      4'hc: font = 7'b0111001;
      4'hd: font = 7'b1011110;
      4'he: font = 7'b1111001;
      4'hf: font = 7'b1110001;
    endcase
  endfunction

  // Two-flop release synchroniser; the scan is held at slot 0 until run rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  // Display and blank registers; blank resets to all-ones so nothing lights before a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      blank_q <= '1;
    end else if (load) begin
      e_q     <= e;
      blank_q <= blank;
    end
  end

  assign wrap = (cnt_q == CntMax);

  // Prescaler and digit index next-state.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!run) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(NDIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // GAP/DRIVE next-state; state_q always reflects the phase of cnt_q.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = StGap;
    end else begin
      unique case (state_q)
        StGap:   if (cnt_d >= CntGap) state_d = StDrive;
        StDrive: if (cnt_d < CntGap)  state_d = StGap;
      endcase
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= StGap;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

`ifdef AFFICHEUR7S_LZB_EN
  logic [NDIGITS-1:0] lz;
  logic               lz_seen;
  // Suppress zeros above the highest non-zero digit; digit 0 always shows.
  always_comb begin
    lz      = '0;
    lz_seen = 1'b0;
    for (int k = NDIGITS - 1; k > 0; k--) begin
      lz_seen = lz_seen | (e_q[4*k +: 4] != 4'h0);
      lz[k]   = ~lz_seen;
    end
  end
  assign blank_eff = blank_q | lz;
`else
  assign blank_eff = blank_q;
`endif

  // Select the nibble and blank bit of the digit being scanned.
  always_comb begin
    nib = 4'h0;
    blk = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        nib = e_q[4*k +: 4];
        blk = blank_eff[k];
      end
    end
  end

  // Output next values in active-high form, then polarity-adjusted.
  always_comb begin
    seg  = 7'h00;
    an_d = '0;
    if (state_q == StDrive) begin
      an_d = NDIGITS'(1) << idx_q;
      seg  = blk ? 7'h00 : font(nib);
    end
    s_d = seg;
    if (COMMON_ANODE != 0) begin
      s_d  = ~seg;
      an_d = ~an_d;
    end
  end

  // Registered outputs; reset forces them off without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= SegOff;
      an_q <= AnOff;
    end else begin
      s_q  <= s_d;
      an_q <= an_d;
    end
  end

  assign s         = s_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_afficheur7s_mux.sv
// Self-checking bench for afficheur7s_mux (NDIGITS=4, DIV=20, GAP=4).
// A common-cathode and a common-anode instance share all inputs.
module tb_afficheur7s_mux;

  localparam int unsigned ND = 4;
  localparam int unsigned DV = 20;
  localparam int unsigned GP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] e = 16'h0;
  logic [3:0]  blank = 4'h0;
  logic [6:0]  s, s_ca;
  logic [3:0]  an, an_ca;
  logic [2:0]  idx, idx_ca;

  int checks = 0;
  int errors = 0;

  // Expected digit patterns written in a..g order (leftmost char = a).
  typedef struct {
    logic [15:0]     e;
    logic [3:0]      blank;
    logic [3:0][6:0] exp;
  } vec_t;

  typedef struct {
    int         slot;
    logic [6:0] s;
    logic [3:0] an;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  afficheur7s_mux #(.NDIGITS(ND), .DIV(DV), .GAP(GP), .COMMON_ANODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .e(e), .load(load), .blank(blank),
    .s(s), .an(an), .digit_idx(idx)
  );

  afficheur7s_mux #(.NDIGITS(ND), .DIV(DV), .GAP(GP), .COMMON_ANODE(1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .e(e), .load(load), .blank(blank),
    .s(s_ca), .an(an_ca), .digit_idx(idx_ca)
  );

  always #5 clk = ~clk;

  // a..g string order to s[0]=a bit order.
  function automatic logic [6:0] to_s(input logic [6:0] abc);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = abc[6-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Return at the first negedge after digit_idx moves to slot k.
  task automatic goto_slot(input int k, output bit ok);
    logic [2:0] prev;
    ok   = 1'b0;
    prev = idx;
    for (int i = 0; i < 2 * ND * DV; i++) begin
      @(negedge clk);
      if (idx == 3'(k) && prev != 3'(k)) begin
        ok = 1'b1;
        return;
      end
      prev = idx;
    end
    check("goto_slot_timeout", 32'(k), 32'hffff_ffff);
  endtask

  // Verify the gap length and the driven pattern of one slot.
  task automatic check_slot(input exp_t x);
    int         n;
    bit         ok;
    logic [6:0] s_inv;
    logic [3:0] an_inv;
    goto_slot(x.slot, ok);
    if (!ok) return;
    @(negedge clk);
    check("gap_s", 32'(s), 32'h0);
    check("gap_an", 32'(an), 32'h0);
    check("gap_s_ca", 32'(s_ca), 32'h7f);
    check("gap_an_ca", 32'(an_ca), 32'hf);
    n = 1;
    for (int i = 0; i < 2 * DV && an == 4'h0; i++) begin
      @(negedge clk);
      if (an == 4'h0) n++;
    end
    check("gap_len", 32'(n), 32'(GP));
    s_inv  = ~x.s;
    an_inv = ~x.an;
    check($sformatf("drive_s_slot%0d", x.slot), 32'(s), 32'(x.s));
    check($sformatf("drive_an_slot%0d", x.slot), 32'(an), 32'(x.an));
    check($sformatf("drive_s_ca_slot%0d", x.slot), 32'(s_ca), 32'(s_inv));
    check($sformatf("drive_an_ca_slot%0d", x.slot), 32'(an_ca), 32'(an_inv));
  endtask

  task automatic do_load(input logic [15:0] ev, input logic [3:0] bv);
    e     = ev;
    blank = bv;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_an_rise(input logic [3:0] pat, output time t);
    logic [3:0] prev;
    t    = 0;
    prev = an;
    for (int i = 0; i < 2 * ND * DV; i++) begin
      @(negedge clk);
      if (an == pat && prev != pat) begin
        t = $time;
        return;
      end
      prev = an;
    end
    check("an_rise_timeout", 32'(pat), 32'hffff_ffff);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    time t1, t2;
    exp_t x;

    vecs[0] = '{e: 16'h1234, blank: 4'b0000,
                exp: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
`ifdef AFFICHEUR7S_LZB_EN
    vecs[1] = '{e: 16'h0070, blank: 4'b0000,
                exp: {7'b0000000, 7'b0000000, 7'b1110010, 7'b1111110}};
`else
    vecs[1] = '{e: 16'h0070, blank: 4'b0000,
                exp: {7'b1111110, 7'b1111110, 7'b1110010, 7'b1111110}};
`endif
    vecs[2] = '{e: 16'habcd, blank: 4'b1010,
                exp: {7'b0000000, 7'b0011111, 7'b0000000, 7'b0111101}};
    vecs[3] = '{e: 16'h9870, blank: 4'b0001,
                exp: {7'b1111011, 7'b1111111, 7'b1110010, 7'b0000000}};
    vecs[4] = '{e: 16'h5e6f, blank: 4'b0000,
                exp: {7'b1011011, 7'b1001111, 7'b1011111, 7'b1000111}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s", 32'(s), 32'h0);
    check("rst_an", 32'(an), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_s_ca", 32'(s_ca), 32'h7f);
    check("rst_an_ca", 32'(an_ca), 32'hf);

    // Release: two sync flops, then GAP+1 cycles to the first lit slot
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && an == 4'h0; i++) begin
      @(negedge clk);
      n++;
    end
    check("first_drive_latency", 32'(n), 32'(GP + 3));
    check("first_drive_an", 32'(an), 32'h1);
    check("first_drive_s_blank", 32'(s), 32'h0);

    // Table-driven vectors through the scoreboard
    for (int v = 0; v < 5; v++) begin
      do_load(vecs[v].e, vecs[v].blank);
      for (int k = 0; k < ND; k++) begin
        x.slot = k;
        x.s    = to_s(vecs[v].exp[k]);
        x.an   = 4'(1 << k);
        sb.push_back(x);
      end
      while (sb.size() > 0) begin
        x = sb.pop_front();
        check_slot(x);
      end
    end

    // Scan period and lit width of digit 0
    wait_an_rise(4'b0001, t1);
    n = 0;
    for (int i = 0; i < 2 * DV && an == 4'b0001; i++) begin
      @(negedge clk);
      if (an == 4'b0001) n++;
    end
    n++;
    check("an0_width", 32'(n), 32'(DV - GP));
    wait_an_rise(4'b0001, t2);
    check("scan_period", 32'((t2 - t1) / 10), 32'(ND * DV));

    // Mid-slot load lands one cycle later (display currently 5E6F)
    goto_slot(2, ok);
    repeat (GP + 2) @(negedge clk);
    check("pre_load_s", 32'(s), 32'(to_s(7'b1001111)));
    do_load(16'hffff, 4'b0100);
    check("load_edge_s_old", 32'(s), 32'(to_s(7'b1001111)));
    @(negedge clk);
    check("load_next_s_blank", 32'(s), 32'h0);
    check("load_next_an", 32'(an), 32'b0100);
    x.slot = 3; x.s = to_s(7'b1000111); x.an = 4'b1000;
    sb.push_back(x);
    x.slot = 0; x.s = to_s(7'b1000111); x.an = 4'b0001;
    sb.push_back(x);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check_slot(x);
    end

    // Reset mid-DRIVE of slot 2: outputs drop with no clock edge
    goto_slot(2, ok);
    repeat (GP + 3) @(negedge clk);
    check("pre_rst_an", 32'(an), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("async_rst_s", 32'(s), 32'h0);
    check("async_rst_an", 32'(an), 32'h0);
    check("async_rst_idx", 32'(idx), 32'h0);
    check("async_rst_s_ca", 32'(s_ca), 32'h7f);
    check("async_rst_an_ca", 32'(an_ca), 32'hf);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && an == 4'h0; i++) begin
      @(negedge clk);
      n++;
    end
    check("rerelease_latency", 32'(n), 32'(GP + 3));
    check("rerelease_an", 32'(an), 32'h1);
    check("rerelease_s_blank", 32'(s), 32'h0);
    x.slot = 1; x.s = 7'h00; x.an = 4'b0010;
    sb.push_back(x);
    x = sb.pop_front();
    check_slot(x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
